// File: rtl/tick_arbiter_pkg.sv
// Shared types and helpers for the tick_arbiter timer-sharing block.
package tick_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int CW_DEFAULT = 16;
    localparam int N_MAX      = 8;

    // Requests at or above ptr take precedence; if none, wrap to the lowest set request.
    function automatic logic [2:0] rr_pick(input logic [N_MAX-1:0] req, input logic [2:0] ptr);
        logic [N_MAX-1:0] masked;
        logic [N_MAX-1:0] src;
        logic [2:0]       pick;
        masked = req & ~((N_MAX'(1) << ptr) - N_MAX'(1));
        src    = (|masked) ? masked : req;
        pick   = '0;
        for (int i = N_MAX - 1; i >= 0; i--) begin
            if (src[i]) pick = 3'(i);
        end
        return pick;
    endfunction

endpackage

// File: rtl/tick_arbiter_tc_timer.sv
// Shared terminal-count timer: latches a terminal count, counts up, flags the match.
module tc_timer
    import tick_arbiter_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [CW-1:0] tc_i,
    output logic [CW-1:0] count_o,
    output logic          tc_hit_o
);

    logic [CW-1:0] tc_q;
    logic [CW-1:0] count_q;

    // Clear wins over increment so the count never wraps past a full-scale terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q    <= '0;
            count_q <= '0;
        end else begin
            if (load_i) tc_q <= tc_i;
            if (clear_i) begin
                count_q <= '0;
            end else if (en_i) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign count_o  = count_q;
    assign tc_hit_o = (count_q == tc_q);

endmodule

// File: rtl/tick_arbiter.sv
// Round-robin arbiter sharing one terminal-count timer among N requesters.
// Build option: define TICK_ARBITER_PERIODIC_EN for gap-free periodic ticks to a sole requester.
module tick_arbiter
    import tick_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = CW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic [N*CW-1:0] tc_in_i,
    output logic [N-1:0]    grant_o,
    output logic [N-1:0]    done_o,
    output logic            busy_o,
    output logic [CW-1:0]   cur_count_o,
    output logic [1:0]      state_o
);

`ifdef TICK_ARBITER_PERIODIC_EN
    localparam bit PERIODIC = 1'b1;
`else
    localparam bit PERIODIC = 1'b0;
`endif

    localparam int IW = $clog2(N);

    state_e        state_q;
    logic [IW-1:0] sel_q;
    logic [IW-1:0] rr_ptr_q;
    logic [N-1:0]  grant_q;
    logic [N-1:0]  done_q;

    logic [IW-1:0] pick_d;
    logic [IW-1:0] rr_ptr_d;
    logic [N-1:0]  sel_onehot;
    logic [N-1:0]  pick_onehot;
    logic          sel_req;
    logic          others_pending;
    logic [CW-1:0] tc_sel;
    logic [CW-1:0] count;
    logic          tc_hit;
    logic          timer_load;
    logic          timer_clear;
    logic          timer_en;

    always_comb begin
        pick_d         = IW'(rr_pick(N_MAX'(req_i), 3'(rr_ptr_q)));
        rr_ptr_d       = (int'(sel_q) == N - 1) ? '0 : sel_q + IW'(1);
        sel_onehot     = '0;
        sel_onehot[sel_q] = 1'b1;
        pick_onehot    = '0;
        pick_onehot[pick_d] = 1'b1;
        sel_req        = req_i[sel_q];
        others_pending = |(req_i & ~sel_onehot);
        tc_sel         = tc_in_i[sel_q*CW +: CW];
        timer_load     = (state_q == ST_LOAD);
        timer_en       = (state_q == ST_RUN);
        // Clearing on abandon as well keeps the count at zero outside RUN.
        timer_clear    = timer_load || ((state_q == ST_RUN) && (tc_hit || !sel_req));
    end

    tc_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (timer_load),
        .clear_i  (timer_clear),
        .en_i     (timer_en),
        .tc_i     (tc_sel),
        .count_o  (count),
        .tc_hit_o (tc_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        sel_q   <= pick_d;
                        grant_q <= pick_onehot;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!sel_req) begin
                        grant_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!sel_req) begin
                        grant_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_IDLE;
                    end else if (tc_hit) begin
                        done_q <= sel_onehot;
                        // A sole holder keeps the grant and the timer restarts from zero.
                        if (!(PERIODIC && !others_pending)) begin
                            grant_q <= '0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign cur_count_o = (state_q == ST_RUN) ? count : '0;
    assign state_o     = state_q;

endmodule

// File: tb/tb_tick_arbiter.sv
// Directed bench for tick_arbiter (N=4, CW=16) with hand-computed expectations.
module tb_tick_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] tc_in;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [15:0] cur_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    tick_arbiter #(.N(4), .CW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .tc_in_i     (tc_in),
        .grant_o     (grant),
        .done_o      (done),
        .busy_o      (busy),
        .cur_count_o (cur_count),
        .state_o     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tc(input int idx, input logic [15:0] v);
        tc_in[idx*16 +: 16] = v;
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst   = 1'b1;
        req   = '0;
        tc_in = '0;

        // Reset state
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(cur_count), 32'h0);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        rst = 1'b0;

        // Single request, tc=5: grant at 1, RUN 2..7, done at 8, idle at 9
        set_tc(0, 16'd5);
        req = 4'b0001;
        tick();
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_load", 32'(state), 32'(S_LOAD));
        chk("single_busy", 32'(busy), 32'h1);
        tick();
        for (int i = 0; i <= 5; i++) begin
            chk("single_run_count", 32'(cur_count), 32'(i));
            chk("single_run_state", 32'(state), 32'(S_RUN));
            chk("single_run_nodone", 32'(done), 32'h0);
            tick();
        end
        chk("single_done", 32'(done), 32'h1);
        chk("single_done_nogrant", 32'(grant), 32'h0);
        chk("single_done_busy", 32'(busy), 32'h1);
        chk("single_done_count", 32'(cur_count), 32'h0);
        req = 4'b0000;
        tick();
        chk("single_idle_busy", 32'(busy), 32'h0);
        chk("single_idle_done", 32'(done), 32'h0);

        // tc=0 on requester 2: one RUN cycle, done two cycles after grant
        set_tc(2, 16'd0);
        req = 4'b0100;
        tick();
        chk("tc0_grant", 32'(grant), 32'h4);
        tick();
        chk("tc0_run", 32'(state), 32'(S_RUN));
        chk("tc0_run_count", 32'(cur_count), 32'h0);
        tick();
        chk("tc0_done", 32'(done), 32'h4);
        chk("tc0_state", 32'(state), 32'(S_DONE));
        req = 4'b0000;
        tick();
        chk("tc0_idle", 32'(state), 32'(S_IDLE));

        // Contention from a fresh pointer: order 0,1,2,3 then 0 again on re-request
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_tc(k, 16'd3);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("cont_grant", 32'(grant), 32'(4'b0001 << order[g]));
            tick();
            chk("cont_run", 32'(state), 32'(S_RUN));
            repeat (4) tick();
            chk("cont_done", 32'(done), 32'(4'b0001 << order[g]));
            chk("cont_done_nogrant", 32'(grant), 32'h0);
            req[order[g]] = 1'b0;
            if (g == 3) req[0] = 1'b1;
            tick();
            chk("cont_idle", 32'(busy), 32'h0);
        end

        // Abandon requester 1 at count 40; requester 2 follows and ignores a later tc change
        set_tc(1, 16'd100);
        set_tc(2, 16'd10);
        req = 4'b0110;
        tick();
        chk("abn_grant1", 32'(grant), 32'h2);
        tick();
        repeat (40) tick();
        chk("abn_count40", 32'(cur_count), 32'd40);
        req[1] = 1'b0;
        tick();
        chk("abn_idle", 32'(state), 32'(S_IDLE));
        chk("abn_nogrant", 32'(grant), 32'h0);
        chk("abn_nodone", 32'(done), 32'h0);
        tick();
        chk("abn_grant2", 32'(grant), 32'h4);
        chk("abn_grant2_nodone", 32'(done), 32'h0);
        tick();
        set_tc(2, 16'd2);
        for (int i = 0; i <= 10; i++) begin
            chk("tcchg_run_state", 32'(state), 32'(S_RUN));
            chk("tcchg_run_count", 32'(cur_count), 32'(i));
            tick();
        end
        chk("tcchg_done", 32'(done), 32'h4);
        req = 4'b0000;
        tick();

        // Reset mid-RUN at count 7, then pointer restarts at index 0
        set_tc(3, 16'd20);
        req = 4'b1000;
        tick();
        chk("rrun_grant3", 32'(grant), 32'h8);
        tick();
        repeat (7) tick();
        chk("rrun_count7", 32'(cur_count), 32'd7);
        rst = 1'b1;
        tick();
        chk("rrun_grant", 32'(grant), 32'h0);
        chk("rrun_done", 32'(done), 32'h0);
        chk("rrun_busy", 32'(busy), 32'h0);
        chk("rrun_count", 32'(cur_count), 32'h0);
        chk("rrun_state", 32'(state), 32'(S_IDLE));
        rst = 1'b0;
        req = 4'b1001;
        tick();
        chk("rrun_after_grant0", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        chk("rrun_abandon_idle", 32'(state), 32'(S_IDLE));

        // Sole requester 3 with tc=4 held high
        set_tc(3, 16'd4);
        req = 4'b1000;
        tick();
        chk("sole_grant", 32'(grant), 32'h8);
        tick();
`ifdef TICK_ARBITER_PERIODIC_EN
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i <= 4; i++) begin
                chk("per_count", 32'(cur_count), 32'(i));
                chk("per_grant", 32'(grant), 32'h8);
                chk("per_done", 32'(done), (i == 0 && p > 0) ? 32'h8 : 32'h0);
                tick();
            end
        end
        chk("per_done_last", 32'(done), 32'h8);
        chk("per_state", 32'(state), 32'(S_RUN));
`else
        repeat (5) tick();
        chk("nper_done", 32'(done), 32'h8);
        chk("nper_nogrant", 32'(grant), 32'h0);
        tick();
        chk("nper_idle", 32'(busy), 32'h0);
        tick();
        chk("nper_regrant", 32'(grant), 32'h8);
`endif
        req = 4'b0000;
        tick();
        tick();
        chk("end_idle", 32'(state), 32'(S_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
